// File: rtl/s_ram_pkg.sv
// Shared sizing constants for the s_ram single-port memory.
package s_ram_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/s_ram_array.sv
// Storage array with async clear, write decode and a combinational read port.
module s_ram_array
    import s_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Every word clears while reset is held, so an interrupted write never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/s_ram.sv
// Single-port RAM: enable qualification, write-first bypass and registered dout.
module s_ram
    import s_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wt,
    input  logic              rd,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic              wr_go;
    logic              rd_go;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] rd_mux;

    assign wr_go = en & wt;
    assign rd_go = en & rd;

    s_ram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_go),
        .addr (add),
        .wdata(din),
        .rdata(rdata)
    );

    // A simultaneous read and write returns the new data.
    assign rd_mux = wt ? din : rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (rd_go) begin
            dout <= rd_mux;
        end
    end

endmodule

// File: tb/tb_s_ram.sv
// Directed self-checking bench for s_ram.
module tb_s_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       wt = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] add = 8'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    s_ram #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .wt   (wt),
        .rd   (rd),
        .add  (add),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    // Drive one operation at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic e, input logic w, input logic r,
                       input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        en = e; wt = w; rd = r; add = a; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        en = 1'b1; wt = 1'b1; din = 8'hFF; add = 8'h05;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async dout=%h want=00", dout);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held dout=%h want=00", dout);
        end
        @(negedge clk);
        en = 1'b0; wt = 1'b0;
        rst_n = 1'b1;
        begin
            logic [7:0] addrs [3] = '{8'h05, 8'hFF, 8'h80};
            foreach (addrs[i]) begin
                cyc(1, 0, 1, addrs[i], 8'hEE);
                n_checks++;
                if (dout !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_read[%0h] dout=%h want=00", addrs[i], dout);
                end
            end
        end
    endtask

    task automatic test_write_read;
        logic [7:0] addrs [4] = '{8'h00, 8'h01, 8'h02, 8'h14};
        logic [7:0] vals  [4] = '{8'h00, 8'h01, 8'h02, 8'h07};
        foreach (addrs[i]) cyc(1, 1, 0, addrs[i], vals[i]);
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL write_no_dout dout=%h want=00", dout);
        end
        foreach (addrs[i]) begin
            cyc(1, 0, 1, addrs[i], 8'hAA);
            n_checks++;
            if (dout !== vals[i]) begin
                n_fail++;
                $display("FAIL read[%0h] dout=%h want=%h", addrs[i], dout, vals[i]);
            end
        end
    endtask

    task automatic test_enable;
        cyc(1, 1, 0, 8'h10, 8'h33);
        cyc(1, 0, 1, 8'h02, 8'h00);
        cyc(0, 1, 0, 8'h10, 8'h55);
        cyc(0, 0, 1, 8'h10, 8'h55);
        n_checks++;
        if (dout !== 8'h02) begin
            n_fail++;
            $display("FAIL en_hold dout=%h want=02", dout);
        end
        cyc(0, 1, 1, 8'h10, 8'h55);
        n_checks++;
        if (dout !== 8'h02) begin
            n_fail++;
            $display("FAIL en_hold_rw dout=%h want=02", dout);
        end
        cyc(1, 0, 0, 8'h10, 8'h77);
        n_checks++;
        if (dout !== 8'h02) begin
            n_fail++;
            $display("FAIL nop_hold dout=%h want=02", dout);
        end
        cyc(1, 0, 1, 8'h10, 8'h00);
        n_checks++;
        if (dout !== 8'h33) begin
            n_fail++;
            $display("FAIL en_mem dout=%h want=33", dout);
        end
    endtask

    task automatic test_write_first;
        cyc(1, 1, 1, 8'h20, 8'hA5);
        n_checks++;
        if (dout !== 8'hA5) begin
            n_fail++;
            $display("FAIL wf_dout dout=%h want=a5", dout);
        end
        cyc(1, 0, 1, 8'h14, 8'h00);
        cyc(1, 0, 1, 8'h20, 8'h00);
        n_checks++;
        if (dout !== 8'hA5) begin
            n_fail++;
            $display("FAIL wf_mem dout=%h want=a5", dout);
        end
    endtask

    task automatic test_boundary;
        logic [7:0] addrs [3] = '{8'hFF, 8'h00, 8'h7F};
        logic [7:0] vals  [3] = '{8'h3C, 8'hC3, 8'h00};
        cyc(1, 1, 0, 8'hFF, 8'h3C);
        cyc(1, 1, 0, 8'h00, 8'hC3);
        foreach (addrs[i]) begin
            cyc(1, 0, 1, addrs[i], 8'h00);
            n_checks++;
            if (dout !== vals[i]) begin
                n_fail++;
                $display("FAIL bound[%0h] dout=%h want=%h", addrs[i], dout, vals[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] addrs [4] = '{8'h40, 8'h41, 8'h14, 8'hFF};
        cyc(1, 1, 0, 8'h40, 8'h11);
        cyc(1, 1, 1, 8'h42, 8'h99);
        @(negedge clk);
        en = 1'b1; wt = 1'b1; rd = 1'b0; add = 8'h41; din = 8'h22;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_async dout=%h want=00", dout);
        end
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; wt = 1'b0;
        rst_n = 1'b1;
        foreach (addrs[i]) begin
            cyc(1, 0, 1, addrs[i], 8'h00);
            n_checks++;
            if (dout !== 8'h00) begin
                n_fail++;
                $display("FAIL rstmid_read[%0h] dout=%h want=00", addrs[i], dout);
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_enable;
        test_write_first;
        test_boundary;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s_ram.md
S_RAM -- requirements
Module: s_ram

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits; depth = 2**ADDR_W (256 words).
REQ-003 clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  chip enable; when low, no read or write occurs.
REQ-006 wt  input  1  write strobe, qualified by en.
REQ-007 rd  input  1  read strobe, qualified by en.
REQ-008 add  input  ADDR_W  word address for read or write.
REQ-009 din  input  DATA_W  write data.
REQ-010 dout  output  DATA_W  registered read data.

Function
REQ-011 Write: at a rising clk edge with en=1 and wt=1, mem[add] SHALL take din; the data is readable from the next edge onward.
REQ-012 Read: at a rising clk edge with en=1, rd=1 and wt=0, dout SHALL take mem[add]; read latency is one clock, and dout holds until the next read, write-through or reset.
REQ-013 Simultaneous rd=1 and wt=1 with en=1: the write SHALL occur and dout SHALL take din in the same edge (write-first).
REQ-014 en=0: memory and dout SHALL hold regardless of rd, wt, add and din.
REQ-015 en=1, rd=0, wt=0: no operation; dout SHALL hold.
REQ-016 Every address 0 .. 2**ADDR_W-1 SHALL be valid; there is no wrap or out-of-range case, and the full add value indexes the array.
REQ-017 Writes to one address SHALL NOT disturb any other address.
REQ-018 dout SHALL be driven only from a register, never combinationally from add or din.

Reset
REQ-019 While rst_n=0, dout SHALL be 0 immediately, without waiting for a clock edge.
REQ-020 While rst_n=0, all memory words SHALL be 0, and writes and reads SHALL be ignored.
REQ-021 The first operation after reset SHALL occur at the first rising clk edge at which rst_n=1.
REQ-022 If reset is asserted in the middle of an operation, it SHALL abort that operation, and the pending write SHALL NOT be committed.

Structure
REQ-023 Shared package s_ram_pkg SHALL hold the default DATA_W and ADDR_W and the derived DEPTH constant.
REQ-024 The storage array and its write decode SHALL live in sub-module s_ram_array, which has clk, rst_n, write enable, address, write data and a combinational read port.
REQ-025 The top level SHALL hold the en/rd/wt qualification, the write-first mux and the dout register.

Verification
REQ-026 Reset: rst_n=0 with en=1, wt=1 and din=0xFF -> dout=0x00 with no clock edge; after release, a read of any address returns 0x00.
REQ-027 Write then read: write 0x00→0x00, 0x01→0x01, 0x02→0x02 and 0x14→0x07 on consecutive edges, then read 0x00, 0x01, 0x02 and 0x14 -> dout = 0x00, 0x01, 0x02, 0x07, each one edge after its address is sampled.
REQ-028 Enable gating: with en=0, write 0x55 to 0x10 and pulse rd -> mem[0x10] is unchanged and dout holds its prior value.
REQ-029 Write-first: en=1, rd=1, wt=1, add=0x20, din=0xA5 -> dout=0xA5 after the edge; a later read of 0x20 returns 0xA5.
REQ-030 Boundary addresses: write 0x3C to 0xFF and 0xC3 to 0x00, then read both -> 0x3C and 0xC3, with no aliasing.
REQ-031 Reset mid-operation: assert rst_n=0 between two write edges -> dout=0 at once; after release, the previously written addresses read back 0x00.
